servo_pwm_bank: RTL and testbench



---
 rtl/servo_pwm_bank.sv | 145 ++++++++++++++
 tb/tb_servo_pwm_bank.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/servo_pwm_bank.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | servo_pwm_bank                                                     |
// | Multi-channel servo PWM, button-stepped targets, frame-synced      |
// | width update with optional slew limit.                             |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module servo_pwm_bank #(
    parameter  int NUM_CH       = 4,
    parameter  int PERIOD_TICKS = 2_000_000,
    parameter  int MIN_TICKS    = 100_000,
    parameter  int MAX_TICKS    = 200_000,
    parameter  int CENTER_TICKS = 150_000,
    parameter  int STEP_TICKS   = 10_000,
    parameter  int SLEW_TICKS   = 0,
    localparam int CW           = $clog2(PERIOD_TICKS + 1),
    localparam int SW           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              BC,
    input  logic              BL,
    input  logic              BR,
    input  logic [SW-1:0]     SEL,
    output logic [2:0]        LEDS,
    output logic [NUM_CH-1:0] pwm
);
    localparam logic [CW-1:0] C_LAST   = CW'(PERIOD_TICKS - 1);
    localparam logic [CW-1:0] C_MIN    = CW'(MIN_TICKS);
    localparam logic [CW-1:0] C_MAX    = CW'(MAX_TICKS);
    localparam logic [CW-1:0] C_CENTER = CW'(CENTER_TICKS);
    localparam logic [CW-1:0] C_STEP   = CW'(STEP_TICKS);
    localparam logic [CW:0]   C_MAX_W  = (CW+1)'(MAX_TICKS);
    localparam logic [CW:0]   C_STEP_W = (CW+1)'(STEP_TICKS);
    localparam logic [CW:0]   C_DN_LIM = (CW+1)'(MIN_TICKS + STEP_TICKS);
    localparam bit PARAMS_OK = (NUM_CH >= 1) && (NUM_CH <= 8) && (MIN_TICKS >= 1)
                            && (MIN_TICKS <= CENTER_TICKS) && (CENTER_TICKS <= MAX_TICKS)
                            && (MAX_TICKS < PERIOD_TICKS);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] target_q [NUM_CH];
    logic [CW-1:0] target_d [NUM_CH];
    logic [2:0]    leds_q, leds_d;
    logic          w_boundary;
    logic          w_sel_ok;
    logic          w_write;
    logic [CW-1:0] w_sel_tgt;
    logic [CW-1:0] w_new;
    logic [CW:0]   w_wide;

    assign w_boundary = (cnt_q == C_LAST);
    assign cnt_d      = w_boundary ? '0 : cnt_q + 1'b1;

    // Explicit mux so an out-of-range SEL never indexes past the array.
    always_comb begin
        w_sel_ok  = 1'b0;
        w_sel_tgt = C_CENTER;
        for (int i = 0; i < NUM_CH; i++) begin
            if (32'(SEL) == i) begin
                w_sel_ok  = 1'b1;
                w_sel_tgt = target_q[i];
            end
        end
    end

    // Saturation tests run one bit wider than the counter so nothing wraps.
    always_comb begin
        w_wide  = {1'b0, w_sel_tgt};
        w_new   = w_sel_tgt;
        w_write = w_sel_ok && (BC || (BR ^ BL));
        if (BC) begin
            w_new = C_CENTER;
        end else if (BR && !BL) begin
            w_new = (w_wide + C_STEP_W > C_MAX_W) ? C_MAX : w_sel_tgt + C_STEP;
        end else if (BL && !BR) begin
            w_new = (w_wide < C_DN_LIM) ? C_MIN : w_sel_tgt - C_STEP;
        end
        for (int i = 0; i < NUM_CH; i++) begin
            target_d[i] = (w_write && (32'(SEL) == i)) ? w_new : target_q[i];
        end
        leds_d = w_sel_ok ? {w_sel_tgt == C_MAX, w_sel_tgt == C_CENTER, w_sel_tgt == C_MIN}
                          : 3'b000;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q  <= '0;
            leds_q <= 3'b010;
            for (int i = 0; i < NUM_CH; i++) begin
                target_q[i] <= C_CENTER;
            end
        end else begin
            cnt_q  <= cnt_d;
            leds_q <= leds_d;
            for (int i = 0; i < NUM_CH; i++) begin
                target_q[i] <= target_d[i];
            end
        end
    end

    assign LEDS = leds_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [CW-1:0] active_q, active_d;
        logic          pwm_q;

        if (SLEW_TICKS == 0) begin : g_direct
            assign active_d = w_boundary ? target_q[i] : active_q;
        end else begin : g_slew
            localparam logic [CW-1:0] C_SLEW =
                CW'((SLEW_TICKS > PERIOD_TICKS) ? PERIOD_TICKS : SLEW_TICKS);
            always_comb begin
                active_d = active_q;
                if (w_boundary) begin
                    if (target_q[i] > active_q) begin
                        active_d = (target_q[i] - active_q > C_SLEW) ? active_q + C_SLEW
                                                                      : target_q[i];
                    end else if (target_q[i] < active_q) begin
                        active_d = (active_q - target_q[i] > C_SLEW) ? active_q - C_SLEW
                                                                      : target_q[i];
                    end
                end
            end
        end

        always_ff @(posedge CLK) begin
            if (RST) begin
                active_q <= C_CENTER;
                pwm_q    <= 1'b0;
            end else begin
                active_q <= active_d;
                pwm_q    <= (cnt_q < active_q);
            end
        end

        assign pwm[i] = pwm_q;
    end

    if (!PARAMS_OK) begin : g_bad_params
        a_params_legal: assert property (@(posedge CLK) 1'b0)
            else $error("servo_pwm_bank: illegal parameter combination");
    end

endmodule
`default_nettype wire

// File: tb/tb_servo_pwm_bank.sv
`default_nettype none
// tb_servo_pwm_bank: three DUT variants (direct, slewed, 3-channel) driven by shared
// stimulus and compared every cycle against a frame-level model.
module tb_servo_pwm_bank;
    localparam int PER  = 100;
    localparam int MINT = 10;
    localparam int CEN  = 15;
    localparam int MAXT = 20;
    localparam int STEP = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       bc  = 1'b0;
    logic       bl  = 1'b0;
    logic       br  = 1'b0;
    logic [1:0] sel = 2'd0;
    logic [2:0] leds0, leds1, leds2;
    logic [1:0] pwm0, pwm1;
    logic [2:0] pwm2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    servo_pwm_bank #(.NUM_CH(2), .PERIOD_TICKS(PER), .MIN_TICKS(MINT), .MAX_TICKS(MAXT),
                     .CENTER_TICKS(CEN), .STEP_TICKS(STEP), .SLEW_TICKS(0)) u_dut0 (
        .CLK(clk), .RST(rst), .BC(bc), .BL(bl), .BR(br), .SEL(sel[0:0]),
        .LEDS(leds0), .pwm(pwm0));

    servo_pwm_bank #(.NUM_CH(2), .PERIOD_TICKS(PER), .MIN_TICKS(MINT), .MAX_TICKS(MAXT),
                     .CENTER_TICKS(CEN), .STEP_TICKS(STEP), .SLEW_TICKS(3)) u_dut1 (
        .CLK(clk), .RST(rst), .BC(bc), .BL(bl), .BR(br), .SEL(sel[0:0]),
        .LEDS(leds1), .pwm(pwm1));

    servo_pwm_bank #(.NUM_CH(3), .PERIOD_TICKS(PER), .MIN_TICKS(MINT), .MAX_TICKS(MAXT),
                     .CENTER_TICKS(CEN), .STEP_TICKS(STEP), .SLEW_TICKS(0)) u_dut2 (
        .CLK(clk), .RST(rst), .BC(bc), .BL(bl), .BR(br), .SEL(sel),
        .LEDS(leds2), .pwm(pwm2));

    // ---------------- behavioural model ----------------
    int         m_cnt;
    int         m_tgt [3][3];
    int         m_act [3][3];
    logic [2:0] e_pwm [3];
    logic [2:0] e_leds [3];
    bit         e_leds_ok [3];
    bit         m_valid = 1'b0;

    function automatic int nch_of(int d);
        return (d == 2) ? 3 : 2;
    endfunction

    function automatic int slew_of(int d);
        return (d == 1) ? 3 : 0;
    endfunction

    function automatic int toward(int act, int tgt, int slew);
        int diff;
        if (slew == 0) return tgt;
        diff = tgt - act;
        if (diff > slew)  return act + slew;
        if (diff < -slew) return act - slew;
        return tgt;
    endfunction

    always @(posedge clk) begin
        int s;
        if (rst) begin
            m_cnt = 0;
            for (int d = 0; d < 3; d++) begin
                for (int i = 0; i < 3; i++) begin
                    m_tgt[d][i] = CEN;
                    m_act[d][i] = CEN;
                end
                e_pwm[d]     = 3'b000;
                e_leds[d]    = 3'b010;
                e_leds_ok[d] = 1'b1;
            end
            m_valid = 1'b1;
        end else begin
            for (int d = 0; d < 3; d++) begin
                s = (d == 2) ? int'(sel) : int'(sel[0]);
                e_pwm[d] = 3'b000;
                for (int i = 0; i < nch_of(d); i++) e_pwm[d][i] = (m_cnt < m_act[d][i]);
                e_leds_ok[d] = (s < nch_of(d));
                if (s < nch_of(d))
                    e_leds[d] = {m_tgt[d][s] == MAXT, m_tgt[d][s] == CEN, m_tgt[d][s] == MINT};
                if (m_cnt == PER - 1)
                    for (int i = 0; i < nch_of(d); i++)
                        m_act[d][i] = toward(m_act[d][i], m_tgt[d][i], slew_of(d));
                if (s < nch_of(d)) begin
                    if (bc)              m_tgt[d][s] = CEN;
                    else if (br && !bl)  m_tgt[d][s] = (m_tgt[d][s] + STEP > MAXT) ? MAXT : m_tgt[d][s] + STEP;
                    else if (bl && !br)  m_tgt[d][s] = (m_tgt[d][s] - STEP < MINT) ? MINT : m_tgt[d][s] - STEP;
                end
            end
            m_cnt = (m_cnt + 1) % PER;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            chk("pwm_d0", {30'd0, pwm0}, {29'd0, e_pwm[0]});
            chk("pwm_d1", {30'd0, pwm1}, {29'd0, e_pwm[1]});
            chk("pwm_d2", {29'd0, pwm2}, {29'd0, e_pwm[2]});
            if (e_leds_ok[0]) chk("leds_d0", {29'd0, leds0}, {29'd0, e_leds[0]});
            if (e_leds_ok[1]) chk("leds_d1", {29'd0, leds1}, {29'd0, e_leds[1]});
            if (e_leds_ok[2]) chk("leds_d2", {29'd0, leds2}, {29'd0, e_leds[2]});
        end
    end

    // ---------------- directed helpers ----------------
    function automatic logic pwm_bit(int d, int ch);
        logic [2:0] p;
        p = (d == 0) ? {1'b0, pwm0} : (d == 1) ? {1'b0, pwm1} : pwm2;
        return p[ch];
    endfunction

    task automatic wait_cnt(input int c);
        int n = 0;
        while (m_cnt != c && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("wait_cnt_timeout", (m_cnt == c) ? 32'd1 : 32'd0, 32'd1);
    endtask

    // Samples 100 consecutive cycles aligned to frame start (pwm lags cnt by one).
    task automatic frame_width(input int d, input int ch, output int w);
        wait_cnt(1);
        w = 0;
        repeat (PER) begin
            if (pwm_bit(d, ch)) w++;
            @(negedge clk);
        end
    endtask

    task automatic press(input logic c, input logic l, input logic r);
        bc = c; bl = l; br = r;
        @(negedge clk);
        bc = 1'b0; bl = 1'b0; br = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int w;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_leds", {29'd0, leds0}, 32'b010);
        chk("reset_pwm", {30'd0, pwm0}, 32'd0);
        rst = 1'b0;

        // Centre width after reset on every channel.
        frame_width(0, 0, w); chk("s1_w_d0c0", w, 15);
        frame_width(0, 1, w); chk("s1_w_d0c1", w, 15);
        frame_width(2, 2, w); chk("s1_w_d2c2", w, 15);

        // Step up to saturation mid-frame, new width lands next frame.
        sel = 2'd1;
        wait_cnt(40);
        repeat (3) press(1'b0, 1'b0, 1'b1);
        chk("s2_leds_max", {29'd0, leds0}, 32'b100);
        frame_width(0, 1, w); chk("s2_w_d0c1", w, 20);
        frame_width(0, 0, w); chk("s2_w_d0c0", w, 15);

        // Step down to saturation, then recentre.
        sel = 2'd0;
        repeat (4) press(1'b0, 1'b1, 1'b0);
        chk("s3_leds_min", {29'd0, leds0}, 32'b001);
        press(1'b1, 1'b0, 1'b0);
        chk("s3_leds_ctr", {29'd0, leds0}, 32'b010);

        // Conflicting buttons and out-of-range select.
        press(1'b0, 1'b1, 1'b1);
        chk("s4_lr_nochg", {29'd0, leds0}, 32'b010);
        press(1'b0, 1'b0, 1'b1);
        chk("s4_step_mid", {29'd0, leds0}, 32'b000);
        press(1'b1, 1'b0, 1'b1);
        chk("s4_bc_wins", {29'd0, leds0}, 32'b010);
        sel = 2'd3;
        press(1'b0, 1'b0, 1'b1);
        sel = 2'd2;
        @(negedge clk); @(negedge clk);
        chk("s4_sel3_ign", {29'd0, leds2}, 32'b010);
        sel = 2'd0;

        // Slew-limited approach and a press on the boundary cycle.
        frame_width(1, 0, w); chk("s5_w_pre", w, 15);
        wait_cnt(40);
        repeat (3) press(1'b0, 1'b0, 1'b1);
        frame_width(1, 0, w); chk("s5_slew_f1", w, 18);
        frame_width(1, 0, w); chk("s5_slew_f2", w, 20);
        wait_cnt(PER - 1);
        bl = 1'b1;
        @(negedge clk);
        bl = 1'b0;
        frame_width(0, 0, w); chk("s5_bnd_f1", w, 20);
        frame_width(0, 0, w); chk("s5_bnd_f2", w, 18);

        // Reset mid-pulse.
        wait_cnt(7);
        chk("s6_pre_high", {31'd0, pwm0[0]}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("s6_pwm0_low", {30'd0, pwm0}, 32'd0);
        chk("s6_pwm1_low", {30'd0, pwm1}, 32'd0);
        chk("s6_leds", {29'd0, leds0}, 32'b010);
        rst = 1'b0;
        frame_width(0, 0, w); chk("s6_w_after", w, 15);

        // Randomised traffic.
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 15) == 0) sel = 2'($urandom_range(0, 3));
            bc  = ($urandom_range(0, 15) == 0);
            bl  = ($urandom_range(0, 5) == 0);
            br  = ($urandom_range(0, 5) == 0);
            rst = ($urandom_range(0, 699) == 0);
            @(negedge clk);
        end
        bc = 1'b0; bl = 1'b0; br = 1'b0; rst = 1'b0;
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5_000_000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
